// File: rtl/qam_carrier_scheduler_if.sv
// Symbol stream handshake between the symbol source and the carrier scheduler.
// The master is the symbol source; the slave is the scheduler's one-entry buffer.
interface qam_carrier_scheduler_if;
  logic [3:0] sym_data;
  logic       sym_valid;
  logic       sym_ready;

  modport master (
    output sym_data,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_data,
    input  sym_valid,
    output sym_ready
  );
endinterface

// File: rtl/qam_carrier_scheduler.sv
// Carrier/symbol sequencer for the QAM modulator.
// Walks the shared sine/cosine LUT address with a programmable step and start
// phase, and holds each 16-QAM symbol for a programmable number of samples.
// A one-entry buffer decouples the symbol source; an empty buffer at a symbol
// boundary can still be served by a same-cycle bypass of the incoming symbol.
module qam_carrier_scheduler #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int LUT_DEPTH     = 100,
  parameter int SPS_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cfg_step,
  input  logic [ADDRESS_WIDTH-1:0] cfg_phase,
  input  logic [SPS_WIDTH-1:0]     cfg_sps,
  input  logic                     start,
  input  logic                     stop,
  qam_carrier_scheduler_if.slave   sym,
  output logic [ADDRESS_WIDTH-1:0] lut_addr,
  output logic                     sample_valid,
  output logic [1:0]               sym_i,
  output logic [1:0]               sym_q,
  output logic                     sym_start,
  output logic                     busy,
  output logic                     underrun,
  output logic                     cfg_err
);

  // Depth constants at the widths the address arithmetic needs. The narrow
  // version may truncate to 0 when LUT_DEPTH is a power of two equal to the
  // address space; the modular subtraction below is still correct then.
  localparam int unsigned                DEPTH_U    = LUT_DEPTH;
  localparam int unsigned                LAST_U     = LUT_DEPTH - 1;
  localparam logic [ADDRESS_WIDTH:0]     DEPTH_EXT  = DEPTH_U[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH-1:0]   DEPTH_LOW  = DEPTH_U[ADDRESS_WIDTH-1:0];
  localparam logic [ADDRESS_WIDTH-1:0]   LAST_ADDR  = LAST_U[ADDRESS_WIDTH-1:0];

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] step_q;
  logic [SPS_WIDTH-1:0]     sps_q;
  logic [SPS_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     stop_pend_q, stop_pend_d;
  logic [3:0]               buf_data_q, buf_data_d;
  logic                     buf_full_q, buf_full_d;
  logic                     ready_q;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [1:0]               sym_i_d, sym_q_d;
  logic                     sym_start_d;

  logic                     cfg_legal;
  logic                     accept;
  logic                     boundary;
  logic                     do_load;
  logic                     latch_cfg;
  logic                     cfg_err_set;
  logic                     load_bypass;
  logic                     load_underrun;
  logic [3:0]               load_sym;
  logic [ADDRESS_WIDTH:0]   addr_sum;
  logic [ADDRESS_WIDTH-1:0] addr_adv;

  assign sym.sym_ready = ready_q;
  assign sample_valid  = (state_q == RUN);
  assign busy          = (state_q == RUN);

  assign cfg_legal = (cfg_step != '0) && (cfg_step <= LAST_ADDR) &&
                     (cfg_phase <= LAST_ADDR) && (cfg_sps != '0);
  assign accept    = sym.sym_valid && ready_q;
  assign boundary  = (state_q == RUN) && (cnt_q == sps_q - 1'b1);

  // Phase accumulator: the extra sum bit keeps addr+step from overflowing
  // before it is folded back into 0..LUT_DEPTH-1.
  assign addr_sum = {1'b0, lut_addr} + {1'b0, step_q};
  assign addr_adv = (addr_sum >= DEPTH_EXT) ? (addr_sum[ADDRESS_WIDTH-1:0] - DEPTH_LOW)
                                            : addr_sum[ADDRESS_WIDTH-1:0];

  // Next-state logic: decides when a symbol is loaded and when RUN ends.
  always_comb begin
    state_d     = state_q;
    do_load     = 1'b0;
    latch_cfg   = 1'b0;
    cfg_err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d   = RUN;
            latch_cfg = 1'b1;
            do_load   = 1'b1;
          end else begin
            cfg_err_set = 1'b1;
          end
        end
      end
      RUN: begin
        if (boundary) begin
          if (stop_pend_q || stop) begin
            state_d = IDLE;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Symbol selection at a load: buffer first, then same-cycle bypass, else the
  // zero symbol, which is what flags an underrun.
  always_comb begin
    load_bypass   = 1'b0;
    load_underrun = 1'b0;
    load_sym      = 4'h0;
    if (do_load) begin
      if (buf_full_q) begin
        load_sym = buf_data_q;
      end else if (accept) begin
        load_sym    = sym.sym_data;
        load_bypass = 1'b1;
      end else begin
        load_underrun = 1'b1;
      end
    end
  end

  // One-entry buffer: drained by a load, filled by any accept not bypassed.
  // An accept only happens while the buffer is empty, so the two never clash.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (do_load && buf_full_q) begin
      buf_full_d = 1'b0;
    end
    if (accept && !load_bypass) begin
      buf_full_d = 1'b1;
      buf_data_d = sym.sym_data;
    end
  end

  // Sample datapath: address walk, sample counter, presented symbol, stop flag.
  always_comb begin
    addr_d      = lut_addr;
    cnt_d       = cnt_q;
    sym_i_d     = sym_i;
    sym_q_d     = sym_q;
    sym_start_d = 1'b0;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      IDLE: begin
        addr_d      = '0;
        cnt_d       = '0;
        sym_i_d     = 2'd0;
        sym_q_d     = 2'd0;
        stop_pend_d = 1'b0;
        if (latch_cfg) begin
          addr_d      = cfg_phase;
          sym_start_d = 1'b1;
          sym_i_d     = load_sym[3:2];
          sym_q_d     = load_sym[1:0];
        end
      end
      RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (boundary) begin
          cnt_d = '0;
          if (state_d == IDLE) begin
            addr_d      = '0;
            sym_i_d     = 2'd0;
            sym_q_d     = 2'd0;
            stop_pend_d = 1'b0;
          end else begin
            addr_d      = addr_adv;
            sym_start_d = 1'b1;
            sym_i_d     = load_sym[3:2];
            sym_q_d     = load_sym[1:0];
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_adv;
        end
      end
      default: begin
        addr_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including sym_ready,
  // which only rises on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      sps_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      buf_data_q  <= 4'h0;
      buf_full_q  <= 1'b0;
      ready_q     <= 1'b0;
      lut_addr    <= '0;
      sym_i       <= 2'd0;
      sym_q       <= 2'd0;
      sym_start   <= 1'b0;
      underrun    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      buf_data_q  <= buf_data_d;
      buf_full_q  <= buf_full_d;
      ready_q     <= !buf_full_d;
      lut_addr    <= addr_d;
      sym_i       <= sym_i_d;
      sym_q       <= sym_q_d;
      sym_start   <= sym_start_d;
      if (latch_cfg) begin
        step_q <= cfg_step;
        sps_q  <= cfg_sps;
      end
      if (load_underrun) begin
        underrun <= 1'b1;
      end
      if (cfg_err_set) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qam_carrier_scheduler.sv
// Self-checking bench for qam_carrier_scheduler: directed scenarios with
// hard-coded expectations plus a randomized run, all compared every cycle
// against a transaction-level model (symbol queue, modulo phase arithmetic).
module tb_qam_carrier_scheduler;
  localparam int AW    = 10;
  localparam int DEPTH = 100;
  localparam int SW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cfg_step;
  logic [AW-1:0] cfg_phase;
  logic [SW-1:0] cfg_sps;
  logic          start;
  logic          stop;
  logic [AW-1:0] lut_addr;
  logic          sample_valid;
  logic [1:0]    sym_i;
  logic [1:0]    sym_q;
  logic          sym_start;
  logic          busy;
  logic          underrun;
  logic          cfg_err;

  qam_carrier_scheduler_if s_if ();

  qam_carrier_scheduler #(
    .ADDRESS_WIDTH (AW),
    .LUT_DEPTH     (DEPTH),
    .SPS_WIDTH     (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_step     (cfg_step),
    .cfg_phase    (cfg_phase),
    .cfg_sps      (cfg_sps),
    .start        (start),
    .stop         (stop),
    .sym          (s_if.slave),
    .lut_addr     (lut_addr),
    .sample_valid (sample_valid),
    .sym_i        (sym_i),
    .sym_q        (sym_q),
    .sym_start    (sym_start),
    .busy         (busy),
    .underrun     (underrun),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs should be after the next edge.
  bit         m_run, m_start, m_stop, m_ready, m_underrun, m_cfgerr;
  int         m_addr, m_pos, m_step, m_sps, m_i, m_q;
  logic [3:0] m_buf[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    bit         accept, loaded, bypassed;
    logic [3:0] sym;
    if (!reset) begin
      m_run = 0; m_start = 0; m_stop = 0; m_ready = 0;
      m_underrun = 0; m_cfgerr = 0;
      m_addr = 0; m_pos = 0; m_i = 0; m_q = 0;
      m_buf.delete();
      return;
    end
    accept   = s_if.sym_valid && m_ready;
    loaded   = 0;
    bypassed = 0;
    if (!m_run) begin
      m_addr = 0; m_i = 0; m_q = 0; m_start = 0; m_stop = 0;
      if (start) begin
        if (cfg_step >= 1 && cfg_step < DEPTH && cfg_phase < DEPTH && cfg_sps >= 1) begin
          m_run  = 1;
          m_step = int'(cfg_step);
          m_sps  = int'(cfg_sps);
          m_addr = int'(cfg_phase);
          m_pos  = 0;
          loaded = 1;
        end else begin
          m_cfgerr = 1;
        end
      end
    end else begin
      if (stop) m_stop = 1;
      if (m_pos == m_sps - 1) begin
        if (m_stop) begin
          m_run = 0; m_addr = 0; m_i = 0; m_q = 0;
          m_start = 0; m_stop = 0; m_pos = 0;
        end else begin
          m_pos  = 0;
          m_addr = (m_addr + m_step) % DEPTH;
          loaded = 1;
        end
      end else begin
        m_pos++;
        m_addr  = (m_addr + m_step) % DEPTH;
        m_start = 0;
      end
    end
    if (loaded) begin
      m_start = 1;
      if (m_buf.size() > 0) begin
        sym = m_buf.pop_front();
      end else if (accept) begin
        sym      = s_if.sym_data;
        bypassed = 1;
      end else begin
        sym        = 4'h0;
        m_underrun = 1;
      end
      m_i = int'(sym[3:2]);
      m_q = int'(sym[1:0]);
    end
    if (accept && !bypassed) m_buf.push_back(s_if.sym_data);
    m_ready = (m_buf.size() == 0);
  endtask

  task automatic compareAll();
    checkOutput("lut_addr",     int'(lut_addr),        m_addr);
    checkOutput("sample_valid", int'(sample_valid),    int'(m_run));
    checkOutput("busy",         int'(busy),            int'(m_run));
    checkOutput("sym_i",        int'(sym_i),           m_i);
    checkOutput("sym_q",        int'(sym_q),           m_q);
    checkOutput("sym_start",    int'(sym_start),       int'(m_start));
    checkOutput("sym_ready",    int'(s_if.sym_ready),  int'(m_ready));
    checkOutput("underrun",     int'(underrun),        int'(m_underrun));
    checkOutput("cfg_err",      int'(cfg_err),         int'(m_cfgerr));
  endtask

  // Drive one cycle of inputs, clock it, then compare on the falling edge.
  task automatic applyStimulus(input bit rst_n, input bit st, input bit sp,
                               input bit vld, input logic [3:0] data);
    reset          = rst_n;
    start          = st;
    stop           = sp;
    s_if.sym_valid = vld;
    s_if.sym_data  = data;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic setCfg(input int step, input int phase, input int sps);
    cfg_step  = AW'(step);
    cfg_phase = AW'(phase);
    cfg_sps   = SW'(sps);
  endtask

  int wrap_addr[4] = '{95, 2, 9, 16};

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    s_if.sym_valid = 1'b0; s_if.sym_data = 4'h0;
    setCfg(1, 0, 4);

    // Reset state
    repeat (3) applyStimulus(0, 0, 0, 0, 4'h0);
    checkOutput("reset_ready", int'(s_if.sym_ready), 0);
    checkOutput("reset_valid", int'(sample_valid), 0);
    applyStimulus(1, 0, 0, 0, 4'h0);
    checkOutput("release_ready", int'(s_if.sym_ready), 1);

    // Basic run with preloaded 0xB, stop during sample 1
    applyStimulus(1, 0, 0, 1, 4'hB);
    checkOutput("preload_ready", int'(s_if.sym_ready), 0);
    applyStimulus(1, 1, 0, 0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("basic_addr",  int'(lut_addr), k);
      checkOutput("basic_i",     int'(sym_i), 2);
      checkOutput("basic_q",     int'(sym_q), 3);
      checkOutput("basic_start", int'(sym_start), (k == 0) ? 1 : 0);
      checkOutput("basic_valid", int'(sample_valid), 1);
      applyStimulus(1, 0, (k == 1), 0, 4'h0);
    end
    checkOutput("stop_valid",    int'(sample_valid), 0);
    checkOutput("stop_addr",     int'(lut_addr), 0);
    checkOutput("basic_underrun", int'(underrun), 0);

    // Wrap-around with bypass at start, then restart at the same phase
    setCfg(7, 95, 4);
    applyStimulus(1, 1, 0, 1, 4'h5);
    for (int k = 0; k < 4; k++) begin
      checkOutput("wrap_addr", int'(lut_addr), wrap_addr[k]);
      applyStimulus(1, 0, (k == 0), 0, 4'h0);
    end
    checkOutput("wrap_underrun", int'(underrun), 0);
    applyStimulus(1, 1, 0, 1, 4'h6);
    checkOutput("restart_addr", int'(lut_addr), 95);
    applyStimulus(1, 0, 1, 0, 4'h0);
    repeat (3) applyStimulus(1, 0, 0, 0, 4'h0);

    // Streaming with a bypassed symbol in every boundary cycle
    setCfg(3, 10, 3);
    applyStimulus(1, 1, 0, 1, 4'($urandom));
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 0, (k == 11), (k % 3 == 2), 4'($urandom));
    end
    checkOutput("stream_underrun", int'(underrun), 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 4'h0);

    // Underrun: one symbol, then nothing
    setCfg(5, 0, 2);
    applyStimulus(1, 1, 0, 1, 4'hF);
    repeat (3) applyStimulus(1, 0, 0, 0, 4'h0);
    checkOutput("underrun_set", int'(underrun), 1);
    checkOutput("underrun_i",   int'(sym_i), 0);
    applyStimulus(1, 0, 1, 0, 4'h0);
    repeat (3) applyStimulus(1, 0, 0, 0, 4'h0);
    checkOutput("underrun_sticky", int'(underrun), 1);

    // Illegal configuration
    setCfg(0, 0, 4);
    applyStimulus(1, 1, 0, 0, 4'h0);
    checkOutput("illegal_err",  int'(cfg_err), 1);
    checkOutput("illegal_busy", int'(busy), 0);

    // Mid-symbol reset
    setCfg(1, 40, 4);
    applyStimulus(1, 1, 0, 1, 4'h9);
    applyStimulus(1, 0, 0, 1, 4'h3);
    applyStimulus(0, 0, 0, 0, 4'h0);
    checkOutput("midreset_addr",  int'(lut_addr), 0);
    checkOutput("midreset_ready", int'(s_if.sym_ready), 0);
    checkOutput("midreset_err",   int'(cfg_err), 0);
    applyStimulus(1, 0, 0, 0, 4'h0);
    checkOutput("midreset_release_ready", int'(s_if.sym_ready), 1);

    // Randomized traffic, configurations occasionally illegal
    for (int c = 0; c < 3000; c++) begin
      setCfg($urandom_range(0, DEPTH), $urandom_range(0, DEPTH), $urandom_range(0, 5));
      applyStimulus($urandom_range(0, 149) != 0, $urandom_range(0, 14) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                    4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_carrier_scheduler.md
# qam_carrier_scheduler

- Sequences the carrier lookup tables and the symbol stream of the QAM modulator.
- Walks the sine/cosine LUT address with a programmable phase step and start phase, so the carrier frequency is configurable.
- Accepts 16-QAM symbols through a valid/ready handshake and holds each symbol for a programmable number of carrier samples.
- Sits between the symbol source and the LUT/mixer datapath: its address output drives both LUT reads, and its I/Q levels feed the mixers.

## Interface

- ADDRESS_WIDTH, 10, LUT address width
- LUT_DEPTH, 100, number of LUT entries; addresses 0..LUT_DEPTH-1
- SPS_WIDTH, 16, width of the samples-per-symbol count
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- cfg_step  input  ADDRESS_WIDTH  address increment per sample; legal range 1..LUT_DEPTH-1
- cfg_phase  input  ADDRESS_WIDTH  start address; legal range 0..LUT_DEPTH-1
- cfg_sps  input  SPS_WIDTH  samples per symbol; legal range ≥1
- start  input  1  pulse: begin transmission
- stop  input  1  pulse: finish the current symbol, then idle
- sym_data  input  4  symbol: [3:2] = I index, [1:0] = Q index
- sym_valid  input  1  sym_data is valid
- sym_ready  output  1  the one-entry symbol buffer is empty
- lut_addr  output  ADDRESS_WIDTH  LUT address for this sample
- sample_valid  output  1  lut_addr, sym_i and sym_q form a valid sample
- sym_i, sym_q  output  2 each  current symbol indices; 0 during an underrun
- sym_start  output  1  first sample of a symbol
- busy  output  1  state is RUN
- underrun  output  1  sticky: a symbol boundary found no symbol available
- cfg_err  output  1  sticky: start was rejected because of an illegal configuration

## Operation

- Reset (reset=0 at a clock edge):
  - All outputs go to 0, including sym_ready.
  - The buffer is emptied and the state goes to IDLE.
  - Reset is honoured in any state, including mid-symbol.
- Buffer:
  - The buffer holds one entry; sym_ready = buffer empty (registered).
  - sym_valid && sym_ready stores sym_data and makes the buffer full.
  - sym_ready is 1 in IDLE as well, so the buffer can be pre-loaded.
- States: IDLE and RUN.
- IDLE:
  - Outputs: sample_valid=0, lut_addr=0, busy=0.
  - stop is ignored.
  - start with a legal configuration goes to RUN and latches cfg_step, cfg_phase and cfg_sps.
  - start with an illegal configuration stays in IDLE and sets cfg_err.
- RUN:
  - One sample per cycle with sample_valid=1.
  - Address update: addr_next = addr + step; if addr_next ≥ LUT_DEPTH, subtract LUT_DEPTH. Compute the sum at ADDRESS_WIDTH+1 bits, so no overflow is possible.
  - sample_cnt counts 0..sps-1; the cycle where sample_cnt = sps-1 is the symbol boundary.
  - At the boundary, the next symbol loads as follows:
    - Buffer full: load from the buffer and empty it.
    - Buffer empty, but sym_valid && sym_ready in the same cycle: bypass sym_data directly, with no underrun.
    - Otherwise: load the zero symbol (I=Q=0) and set underrun.
  - start is ignored in RUN.
  - stop sets stop_pending. At the next boundary the state goes to IDLE instead of loading a symbol, and the buffer contents are kept.
  - stop_pending clears on entry to IDLE.
  - The address phase is continuous across symbol boundaries; it is not re-phased per symbol.
- Entering RUN follows the same load rules as a boundary, so a start with an empty buffer and no sym_valid flags underrun.

## Timing

- Cycle N: start accepted in IDLE.
- Cycle N+1 outputs:
  - sample_valid=1, busy=1, sym_start=1
  - lut_addr = cfg_phase, sample_cnt=0
  - sym_i/sym_q = the loaded symbol
- Each later cycle: lut_addr advances by step, modulo LUT_DEPTH.
- sym_start is high on sample 0 of every symbol.
- A symbol loaded at boundary cycle B is presented from B+1.
- With sps=1, every RUN cycle is a boundary.
- Stop, with the boundary at cycle B:
  - B is the last cycle with sample_valid=1.
  - At B+1: sample_valid=0, busy=0, lut_addr=0.
- Stop arriving in the boundary cycle itself takes effect at that boundary.
- sym_ready reflects the buffer state one cycle after an accept or a load.
- The LUT read latency belongs to the consumer; this block's outputs are registered.
- Underrun and cfg_err stay set until reset.

## Test plan

- Basic run: reset, step=1, phase=0, sps=4, pre-load symbol 0xB.
  - Pulse start.
  - Required: lut_addr 0,1,2,3 with I=2, Q=3; sym_start only on the first sample.
- Wrap-around: step=7, phase=95, LUT_DEPTH=100.
  - Required: addresses 95, 2, 9, 16.
- Symbol streaming: sps=3, one symbol per boundary, using the bypass in the boundary cycle.
  - Required: back-to-back symbols with no gaps and underrun=0.
- Underrun: sps=2, stop supplying symbols.
  - Required: I=Q=0 from the next symbol; underrun=1 and stays set.
- Stop and restart:
  - Stop at sample 1 of a 4-sample symbol → two more samples, then sample_valid=0.
  - Restart → lut_addr = phase.
- Illegal config and mid-run reset:
  - step=0 plus start → IDLE with cfg_err=1.
  - reset=0 mid-symbol → all outputs 0 next cycle; sym_ready=1 the cycle after release.
